// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: pipeline bundles, data-bus structs, size codes and op helpers.
// MEM_MISALIGN_CHECK_EN adds a misalign flag to mem_data_t.
package mem_stage_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int NBYTES = DATA_W / 8;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic [3:0] {
    MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LD, MEM_LBU, MEM_LHU, MEM_LWU,
    MEM_SB, MEM_SH, MEM_SW, MEM_SD
  } mem_op_t;

  typedef struct packed {
    logic    regwrite;
    mem_op_t memop;
  } ctl_t;

  typedef struct packed {
    logic [ADDR_W-1:0] aluout;
    logic [DATA_W-1:0] rd;
    ctl_t              ctl;
    logic [4:0]        dst;
    logic [31:0]       instr;
  } exec_data_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    msize_t            size;
    logic [NBYTES-1:0] strobe;
    logic [DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } dbus_resp_t;

  typedef struct packed {
`ifdef MEM_MISALIGN_CHECK_EN
    logic              misalign;
`endif
    ctl_t              ctl;
    logic [4:0]        dst;
    logic [31:0]       instr;
    logic [DATA_W-1:0] result;
  } mem_data_t;

  function automatic logic is_load(mem_op_t op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LD, MEM_LBU, MEM_LHU, MEM_LWU};
  endfunction

  function automatic logic is_store(mem_op_t op);
    return op inside {MEM_SB, MEM_SH, MEM_SW, MEM_SD};
  endfunction

  function automatic logic op_unsigned(mem_op_t op);
    return op inside {MEM_LBU, MEM_LHU, MEM_LWU};
  endfunction

  function automatic msize_t op_size(mem_op_t op);
    msize_t s;
    s = MSIZE8;
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: s = MSIZE1;
      MEM_LH, MEM_LHU, MEM_SH: s = MSIZE2;
      MEM_LW, MEM_LWU, MEM_SW: s = MSIZE4;
      default:                 s = MSIZE8;
    endcase
    return s;
  endfunction

  function automatic logic [NBYTES-1:0] base_strobe(msize_t s);
    logic [NBYTES-1:0] b;
    b = '1;
    case (s)
      MSIZE1:  b = 8'h01;
      MSIZE2:  b = 8'h03;
      MSIZE4:  b = 8'h0F;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  function automatic logic misaligned(msize_t s, logic [2:0] off);
    logic m;
    m = 1'b0;
    case (s)
      MSIZE2:  m = off[0];
      MSIZE4:  m = |off[1:0];
      MSIZE8:  m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_extend.sv
// Load data aligner: shifts the addressed bytes down to bit 0, then sign- or zero-extends by size.
import mem_stage_pkg::*;

module mem_extend (
  input  logic [DATA_W-1:0] i_data,
  input  logic [2:0]        i_off,
  input  msize_t            i_size,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_raw;

  assign w_raw = i_data >> {i_off, 3'b000};

  always_comb begin
    o_data = w_raw;
    case (i_size)
      MSIZE1:  o_data = {{56{~i_unsigned & w_raw[7]}},  w_raw[7:0]};
      MSIZE2:  o_data = {{48{~i_unsigned & w_raw[15]}}, w_raw[15:0]};
      MSIZE4:  o_data = {{32{~i_unsigned & w_raw[31]}}, w_raw[31:0]};
      default: o_data = w_raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results through, runs dbus handshakes for loads/stores.
// MEM_MISALIGN_CHECK_EN short-circuits misaligned accesses with a flagged result instead of a bus request.
import mem_stage_pkg::*;

module mem_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  exec_data_t dataE,
  output dbus_req_t  dreq,
  input  dbus_resp_t dresp,
  output logic       out_valid,
  input  logic       out_ready,
  output mem_data_t  dataM
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_out_valid;
  mem_data_t         r_out;
  logic [ADDR_W-1:0] r_addr;
  msize_t            r_size;
  logic [NBYTES-1:0] r_strobe;
  logic [DATA_W-1:0] r_wdata;
  mem_op_t           r_op;
  ctl_t              r_ctl;
  logic [4:0]        r_dst;
  logic [31:0]       r_instr;

  logic              w_accept, w_is_mem, w_misalign, w_done, w_req_valid;
  msize_t            w_size_e;
  logic [2:0]        w_off_e;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_ld_unsigned;
  logic              w_unused;

  assign w_unused = dresp.addr_ok;
  assign w_is_mem = (dataE.ctl.memop != MEM_NONE);
  assign w_size_e = op_size(dataE.ctl.memop);
  assign w_off_e  = dataE.aluout[2:0];
  assign w_accept = in_valid && in_ready;
  assign w_done   = (r_state == REQ) && dresp.data_ok;

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misalign = w_is_mem && misaligned(w_size_e, w_off_e);
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_req_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !r_out_valid || out_ready;
        if (w_accept && w_is_mem && !w_misalign) w_state_nxt = REQ;
      end
      REQ: begin
        w_req_valid = 1'b1;
        if (dresp.data_ok) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_ld_unsigned = op_unsigned(r_op);

  mem_extend u_extend (
    .i_data     (dresp.data),
    .i_off      (r_addr[2:0]),
    .i_size     (r_size),
    .i_unsigned (w_ld_unsigned),
    .o_data     (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_addr      <= '0;
      r_size      <= MSIZE1;
      r_strobe    <= '0;
      r_wdata     <= '0;
      r_op        <= MEM_NONE;
      r_ctl       <= '0;
      r_dst       <= '0;
      r_instr     <= '0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (w_accept) begin
        if (!w_is_mem || w_misalign) begin
          r_out.ctl    <= dataE.ctl;
          r_out.dst    <= dataE.dst;
          r_out.instr  <= dataE.instr;
          r_out.result <= dataE.aluout;
`ifdef MEM_MISALIGN_CHECK_EN
          r_out.misalign <= w_misalign;
`endif
          r_out_valid  <= 1'b1;
        end else begin
          // Bus fields are fixed here so they stay stable for the whole request.
          r_addr   <= dataE.aluout;
          r_size   <= w_size_e;
          r_strobe <= is_store(dataE.ctl.memop) ? (base_strobe(w_size_e) << w_off_e) : '0;
          r_wdata  <= dataE.rd << {w_off_e, 3'b000};
          r_op     <= dataE.ctl.memop;
          r_ctl    <= dataE.ctl;
          r_dst    <= dataE.dst;
          r_instr  <= dataE.instr;
        end
      end
      if (w_done) begin
        r_out.ctl    <= r_ctl;
        r_out.dst    <= r_dst;
        r_out.instr  <= r_instr;
        r_out.result <= is_load(r_op) ? w_ld_data : '0;
`ifdef MEM_MISALIGN_CHECK_EN
        r_out.misalign <= 1'b0;
`endif
        r_out_valid  <= 1'b1;
      end
    end
  end

  always_comb begin
    dreq        = '0;
    dreq.valid  = w_req_valid;
    dreq.addr   = r_addr;
    dreq.size   = r_size;
    dreq.strobe = r_strobe;
    dreq.data   = r_wdata;
  end

  assign out_valid = r_out_valid;
  assign dataM     = r_out;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table of single ops plus output-hold and mid-request reset sequences.
import mem_stage_pkg::*;

module tb_mem_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  exec_data_t dataE;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       out_valid;
  logic       out_ready;
  mem_data_t  dataM;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataE     (dataE),
    .dreq      (dreq),
    .dresp     (dresp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataM     (dataM)
  );

  typedef struct {
    mem_op_t     op;
    logic [63:0] addr;
    logic [63:0] rd;
    logic [63:0] bdata;
    int          waitc;
    logic        exp_req;
    msize_t      exp_size;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
    logic [63:0] exp_res;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input mem_op_t op, input logic [63:0] addr, input logic [63:0] rd,
                     input logic [63:0] bdata, input int waitc, input logic exp_req,
                     input msize_t exp_size, input logic [7:0] exp_strb,
                     input logic [63:0] exp_wdata, input logic [63:0] exp_res, input logic exp_mis);
    vec_t v;
    v = '{op, addr, rd, bdata, waitc, exp_req, exp_size, exp_strb, exp_wdata, exp_res, exp_mis};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input mem_op_t op, input logic [63:0] addr, input logic [63:0] rd,
                          input logic [4:0] dst, input logic [31:0] instr);
    in_valid             = 1'b1;
    dataE.aluout         = addr;
    dataE.rd             = rd;
    dataE.ctl.memop      = op;
    dataE.ctl.regwrite   = !is_store(op);
    dataE.dst            = dst;
    dataE.instr          = instr;
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    logic [4:0]  dst;
    logic [31:0] instr;
    v     = vecs[i];
    dst   = 5'(i + 1);
    instr = 32'h1000 + 32'(i);
    out_ready = 1'b1;
    drive_op(v.op, v.addr, v.rd, dst, instr);
    #1;
    chk($sformatf("v%0d in_ready_idle", i), 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    if (!v.exp_req) begin
      chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d no_dreq", i), 64'(dreq.valid), 64'd0);
    end else begin
      chk($sformatf("v%0d dreq_valid", i), 64'(dreq.valid), 64'd1);
      chk($sformatf("v%0d dreq_addr", i), dreq.addr, v.addr);
      chk($sformatf("v%0d dreq_size", i), 64'(dreq.size), 64'(v.exp_size));
      chk($sformatf("v%0d dreq_strobe", i), 64'(dreq.strobe), 64'(v.exp_strb));
      chk($sformatf("v%0d dreq_data", i), dreq.data, v.exp_wdata);
      for (int w = 0; w <= v.waitc; w++) begin
        chk($sformatf("v%0d in_ready_req%0d", i, w), 64'(in_ready), 64'd0);
        chk($sformatf("v%0d dreq_hold%0d", i, w), dreq.addr, v.addr);
        dresp.addr_ok = 1'b1;
        if (w == v.waitc) begin
          dresp.data_ok = 1'b1;
          dresp.data    = v.bdata;
        end
        step();
        dresp = '0;
        if (w < v.waitc)
          chk($sformatf("v%0d out_valid_early%0d", i, w), 64'(out_valid), 64'd0);
      end
      chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d dreq_idle", i), 64'(dreq.valid), 64'd0);
    end
    chk($sformatf("v%0d result", i), dataM.result, v.exp_res);
    chk($sformatf("v%0d dst", i), 64'(dataM.dst), 64'(dst));
    chk($sformatf("v%0d instr", i), 64'(dataM.instr), 64'(instr));
    chk($sformatf("v%0d memop", i), 64'(dataM.ctl.memop), 64'(v.op));
`ifdef MEM_MISALIGN_CHECK_EN
    chk($sformatf("v%0d misalign", i), 64'(dataM.misalign), 64'(v.exp_mis));
`endif
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dataE     = '0;
    dresp     = '0;

    //   op        addr               rd                      bus data               wt req size    strb   wdata                  result                 mis
    add(MEM_NONE, 64'h5,             64'h0,                  64'h0,                 0, 0, MSIZE1, 8'h00, 64'h0,                 64'h5,                 0);
    add(MEM_LB,   64'h1003,          64'h0,                  64'h0000_0000_8000_0000, 2, 1, MSIZE1, 8'h00, 64'h0,               64'hFFFF_FFFF_FFFF_FF80, 0);
    add(MEM_SH,   64'h2006,          64'h1234,               64'h0,                 0, 1, MSIZE2, 8'hC0, 64'h1234_0000_0000_0000, 64'h0,               0);
    add(MEM_LWU,  64'h4,             64'h0,                  64'hFFFF_FFFF_0000_0000, 0, 1, MSIZE4, 8'h00, 64'h0,               64'h0000_0000_FFFF_FFFF, 0);
    add(MEM_LH,   64'h2,             64'h0,                  64'h0000_0000_8001_0000, 1, 1, MSIZE2, 8'h00, 64'h0,               64'hFFFF_FFFF_FFFF_8001, 0);
    add(MEM_LW,   64'h0,             64'h0,                  64'h0000_0000_7FFF_FFFF, 0, 1, MSIZE4, 8'h00, 64'h0,               64'h0000_0000_7FFF_FFFF, 0);
    add(MEM_LD,   64'h8,             64'h0,                  64'h0123_4567_89AB_CDEF, 1, 1, MSIZE8, 8'h00, 64'h0,               64'h0123_4567_89AB_CDEF, 0);
    add(MEM_SD,   64'h10,            64'hDEAD_BEEF_CAFE_F00D, 64'h0,                0, 1, MSIZE8, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,               0);
    add(MEM_LBU,  64'h7,             64'h0,                  64'hF000_0000_0000_0000, 0, 1, MSIZE1, 8'h00, 64'h0,               64'h0000_0000_0000_00F0, 0);
    add(MEM_SW,   64'h4,             64'h1122_3344,          64'h0,                 1, 1, MSIZE4, 8'hF0, 64'h1122_3344_0000_0000, 64'h0,               0);
    add(MEM_SB,   64'h1,             64'hAB,                 64'h0,                 0, 1, MSIZE1, 8'h02, 64'h0000_0000_0000_AB00, 64'h0,               0);
    add(MEM_LHU,  64'h6,             64'h0,                  64'hBEEF_0000_0000_0000, 0, 1, MSIZE2, 8'h00, 64'h0,               64'h0000_0000_0000_BEEF, 0);
`ifdef MEM_MISALIGN_CHECK_EN
    add(MEM_LW,   64'h2,             64'h0,                  64'h0,                 0, 0, MSIZE4, 8'h00, 64'h0,                 64'h2,                 1);
`endif

    step();
    step();
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst dreq_valid", 64'(dreq.valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst dataM_zero", 64'(dataM == '0), 64'd1);
    reset = 1'b0;
    step();

    foreach (vecs[i]) run_vec(i);

    // Completed load held by writeback back-pressure.
    out_ready = 1'b1;
    drive_op(MEM_LD, 64'h18, 64'h0, 5'd7, 32'hA0);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dresp.data_ok = 1'b1;
    dresp.addr_ok = 1'b1;
    dresp.data    = 64'h55AA_55AA_0F0F_F0F0;
    step();
    dresp = '0;
    drive_op(MEM_NONE, 64'h99, 64'h0, 5'd8, 32'hA1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("hold%0d out_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("hold%0d result", k), dataM.result, 64'h55AA_55AA_0F0F_F0F0);
      chk($sformatf("hold%0d dst", k), 64'(dataM.dst), 64'd7);
      chk($sformatf("hold%0d in_ready", k), 64'(in_ready), 64'd0);
      chk($sformatf("hold%0d dreq_valid", k), 64'(dreq.valid), 64'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("drain in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("drain next_valid", 64'(out_valid), 64'd1);
    chk("drain next_result", dataM.result, 64'h99);
    step();
    chk("drain empty", 64'(out_valid), 64'd0);

    // Reset while a request is outstanding.
    drive_op(MEM_LB, 64'h40, 64'h0, 5'd9, 32'hB0);
    step();
    in_valid = 1'b0;
    chk("midrst dreq_before", 64'(dreq.valid), 64'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst dreq_valid", 64'(dreq.valid), 64'd0);
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst in_ready", 64'(in_ready), 64'd1);
    chk("midrst dataM_zero", 64'(dataM == '0), 64'd1);
    step();
    chk("midrst still_idle", 64'(dreq.valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
